// File: rtl/prt_pkg.sv
// Shared defaults, derived widths and FSM state encodings for the PRT packet controller.
package prt_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int MEM_DEPTH_DEF  = 1518;
   localparam int NUM_SLOTS_DEF  = 10;
   localparam int SLOT_W_DEF     = $clog2(NUM_SLOTS_DEF);
   localparam int LEN_W_DEF      = $clog2(MEM_DEPTH_DEF + 1);

   // Bit of the PRT read entry that flags the byte as valid (sits above the data byte).
   localparam int RE_VALID_BIT   = DATA_WIDTH_DEF;

   typedef enum logic [2:0] {
      W_IDLE, W_ALLOC, W_DATA, W_FIN, W_NOTIFY, W_DINV
   } wr_state_t;

   typedef enum logic [2:0] {
      R_IDLE, R_START, R_REQ, R_CAP, R_OUT, R_INV
   } rd_state_t;

endpackage

// File: rtl/prt_inv_arb.sv
// Two-requester fixed-priority arbiter for the single PRT invalidate port.
// The hi requester (read path) always wins; nothing is granted while the port is not ready.
module prt_inv_arb
   import prt_pkg::*;
#(
   parameter int SLOT_W = SLOT_W_DEF
) (
   input  logic              hi_req,
   input  logic [SLOT_W-1:0] hi_slot,
   input  logic              lo_req,
   input  logic [SLOT_W-1:0] lo_slot,
   input  logic              inv_rdy,
   output logic              hi_gnt,
   output logic              lo_gnt,
   output logic              inv_en,
   output logic [SLOT_W-1:0] inv_slot
);

   // Pick the winner and steer its slot onto the shared port.
   always_comb begin
      hi_gnt   = 1'b0;
      lo_gnt   = 1'b0;
      inv_en   = 1'b0;
      inv_slot = '0;
      if (inv_rdy && hi_req) begin
         hi_gnt   = 1'b1;
         inv_en   = 1'b1;
         inv_slot = hi_slot;
      end else if (inv_rdy && lo_req) begin
         lo_gnt   = 1'b1;
         inv_en   = 1'b1;
         inv_slot = lo_slot;
      end
   end

endmodule

// File: rtl/prt_pkt_ctrl.sv
// Sequencing controller in front of the PRT packet buffer: stores ingress packets into
// PRT slots, reports them to the classifier, and on a verdict streams them out or drops them.
module prt_pkt_ctrl
   import prt_pkg::*;
#(
   parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter  int MEM_DEPTH  = MEM_DEPTH_DEF,
   parameter  int NUM_SLOTS  = NUM_SLOTS_DEF,
   localparam int SLOT_W     = $clog2(NUM_SLOTS),
   localparam int LEN_W      = $clog2(MEM_DEPTH + 1)
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  done_valid,
   input  logic                  done_ready,
   output logic [SLOT_W-1:0]     done_slot,
   output logic [LEN_W-1:0]      done_len,
   input  logic                  verdict_valid,
   output logic                  verdict_ready,
   input  logic [SLOT_W-1:0]     verdict_slot,
   input  logic                  verdict_accept,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  err_bad_verdict,
   output logic                  err_short_read,
   output logic                  prt_EN_start_writing,
   output logic                  prt_EN_write,
   output logic                  prt_EN_finish,
   output logic                  prt_EN_start_reading,
   output logic                  prt_EN_read,
   output logic                  prt_EN_invalidate,
   input  logic                  prt_RDY_start_writing,
   input  logic                  prt_RDY_write,
   input  logic                  prt_RDY_finish,
   input  logic                  prt_RDY_start_reading,
   input  logic                  prt_RDY_read,
   input  logic                  prt_RDY_invalidate,
   input  logic [SLOT_W-1:0]     prt_alloc_slot,
   output logic [DATA_WIDTH-1:0] prt_write_data,
   output logic [SLOT_W-1:0]     prt_read_slot,
   output logic [SLOT_W-1:0]     prt_inv_slot,
   input  logic [DATA_WIDTH:0]   prt_read_entry,
   input  logic                  prt_slot_free
);

   wr_state_t             w_state_reg, w_state_next;
   logic [SLOT_W-1:0]     w_slot_reg;
   logic [LEN_W-1:0]      w_len_reg;
   logic                  w_ovf_reg;
   logic                  w_full, w_beat, set_pend, w_inv_req, w_inv_gnt;

   rd_state_t             r_state_reg, r_state_next;
   logic [SLOT_W-1:0]     r_slot_reg;
   logic [LEN_W-1:0]      r_len_reg, r_cnt_reg;
   logic [DATA_WIDTH-1:0] r_data_reg;
   logic                  r_short_reg, r_inv_req, r_inv_gnt;
   logic                  v_take, v_hit, v_slot_ok;

   logic [NUM_SLOTS-1:0]  pending_reg, pend_set, pend_clr;
   logic [LEN_W-1:0]      len_table [NUM_SLOTS];
   logic                  run_reg, err_bad_reg, err_short_reg;

   // Beats past the buffer depth are swallowed rather than written.
   assign w_full    = (w_len_reg == LEN_W'(MEM_DEPTH));
   assign v_slot_ok = ({1'b0, verdict_slot} < (SLOT_W + 1)'(NUM_SLOTS));
   assign v_hit     = v_slot_ok && pending_reg[verdict_slot];

   assign done_slot       = w_slot_reg;
   assign done_len        = w_len_reg;
   assign out_data        = r_data_reg;
   assign out_last        = (r_state_reg == R_OUT) &&
                            (r_short_reg || (r_cnt_reg == r_len_reg - LEN_W'(1)));
   assign err_bad_verdict = err_bad_reg;
   assign err_short_read  = err_short_reg;

   // Write FSM next state and PRT write-side enables.
   always_comb begin
      w_state_next         = w_state_reg;
      in_ready             = 1'b0;
      prt_EN_start_writing = 1'b0;
      prt_EN_write         = 1'b0;
      prt_EN_finish        = 1'b0;
      prt_write_data       = '0;
      done_valid           = 1'b0;
      w_inv_req            = 1'b0;
      w_beat               = 1'b0;
      set_pend             = 1'b0;
      case (w_state_reg)
         W_IDLE: begin
            if (in_valid && prt_slot_free && prt_RDY_start_writing) begin
               prt_EN_start_writing = 1'b1;
               w_state_next         = W_ALLOC;
            end
         end
         W_ALLOC: w_state_next = W_DATA;
         W_DATA: begin
            in_ready = w_full ? 1'b1 : prt_RDY_write;
            w_beat   = in_valid && in_ready;
            if (w_beat && !w_full) begin
               prt_EN_write   = 1'b1;
               prt_write_data = in_data;
            end
            if (w_beat && in_last) w_state_next = W_FIN;
         end
         W_FIN: begin
            if (prt_RDY_finish) begin
               prt_EN_finish = 1'b1;
               if (w_ovf_reg || (w_len_reg == '0)) begin
                  w_state_next = W_DINV;
               end else begin
                  set_pend     = 1'b1;
                  w_state_next = W_NOTIFY;
               end
            end
         end
         W_NOTIFY: begin
            done_valid = 1'b1;
            if (done_ready) w_state_next = W_IDLE;
         end
         W_DINV: begin
            w_inv_req = 1'b1;
            if (w_inv_gnt) w_state_next = W_IDLE;
         end
         default: w_state_next = W_IDLE;
      endcase
   end

   // Write FSM state, latched slot, running length and overflow flag.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         w_state_reg <= W_IDLE;
         w_slot_reg  <= '0;
         w_len_reg   <= '0;
         w_ovf_reg   <= 1'b0;
      end else begin
         w_state_reg <= w_state_next;
         if (w_state_reg == W_ALLOC) w_slot_reg <= prt_alloc_slot;
         if (prt_EN_start_writing) begin
            w_len_reg <= '0;
            w_ovf_reg <= 1'b0;
         end else if (w_beat) begin
            if (w_full) w_ovf_reg <= 1'b1;
            else        w_len_reg <= w_len_reg + LEN_W'(1);
         end
      end
   end

   // Read FSM next state, verdict intake and PRT read-side enables.
   always_comb begin
      r_state_next         = r_state_reg;
      verdict_ready        = 1'b0;
      v_take               = 1'b0;
      prt_EN_start_reading = 1'b0;
      prt_EN_read          = 1'b0;
      prt_read_slot        = '0;
      out_valid            = 1'b0;
      r_inv_req            = 1'b0;
      case (r_state_reg)
         R_IDLE: begin
            verdict_ready = run_reg;
            v_take        = verdict_valid && run_reg;
            if (v_take && v_hit) r_state_next = verdict_accept ? R_START : R_INV;
         end
         R_START: begin
            if (prt_RDY_start_reading) begin
               prt_EN_start_reading = 1'b1;
               prt_read_slot        = r_slot_reg;
               r_state_next         = R_REQ;
            end
         end
         R_REQ: begin
            if (prt_RDY_read) begin
               prt_EN_read  = 1'b1;
               r_state_next = R_CAP;
            end
         end
         R_CAP: r_state_next = R_OUT;
         R_OUT: begin
            out_valid = 1'b1;
            if (out_ready) r_state_next = out_last ? R_INV : R_REQ;
         end
         R_INV: begin
            r_inv_req = 1'b1;
            if (r_inv_gnt) r_state_next = R_IDLE;
         end
         default: r_state_next = R_IDLE;
      endcase
   end

   // Read FSM state, slot/length load on verdict, byte capture and error flags.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state_reg   <= R_IDLE;
         r_slot_reg    <= '0;
         r_len_reg     <= '0;
         r_cnt_reg     <= '0;
         r_data_reg    <= '0;
         r_short_reg   <= 1'b0;
         err_bad_reg   <= 1'b0;
         err_short_reg <= 1'b0;
         run_reg       <= 1'b0;
      end else begin
         run_reg     <= 1'b1;
         r_state_reg <= r_state_next;
         err_bad_reg <= v_take && !v_hit;
         if (v_take && v_hit) begin
            r_slot_reg  <= verdict_slot;
            r_len_reg   <= len_table[verdict_slot];
            r_cnt_reg   <= '0;
            r_short_reg <= 1'b0;
         end
         if (r_state_reg == R_CAP) begin
            r_data_reg <= prt_read_entry[DATA_WIDTH-1:0];
            if (!prt_read_entry[DATA_WIDTH]) begin
               r_short_reg   <= 1'b1;
               err_short_reg <= 1'b1;
            end
         end
         if ((r_state_reg == R_OUT) && out_ready && !out_last) r_cnt_reg <= r_cnt_reg + LEN_W'(1);
      end
   end

   // Per-slot set/clear decode for the pending bitmap.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         assign pend_set[gi] = set_pend && (w_slot_reg == SLOT_W'(gi));
         assign pend_clr[gi] = v_take && v_hit && (verdict_slot == SLOT_W'(gi));
      end
   endgenerate

   // Pending bitmap and length table; a slot is set by the writer and cleared by its verdict.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pending_reg <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) len_table[i] <= '0;
      end else begin
         pending_reg <= (pending_reg & ~pend_clr) | pend_set;
         if (set_pend) len_table[w_slot_reg] <= w_len_reg;
      end
   end

   prt_inv_arb #(.SLOT_W(SLOT_W)) u_inv_arb (
      .hi_req   (r_inv_req),
      .hi_slot  (r_slot_reg),
      .lo_req   (w_inv_req),
      .lo_slot  (w_slot_reg),
      .inv_rdy  (prt_RDY_invalidate),
      .hi_gnt   (r_inv_gnt),
      .lo_gnt   (w_inv_gnt),
      .inv_en   (prt_EN_invalidate),
      .inv_slot (prt_inv_slot)
   );

endmodule

// File: tb/tb_prt_pkt_ctrl.sv
// Directed bench for prt_pkt_ctrl with a behavioural PRT buffer model.
module tb_prt_pkt_ctrl;
   import prt_pkg::*;

   localparam int DW = DATA_WIDTH_DEF;
   localparam int MD = MEM_DEPTH_DEF;
   localparam int NS = NUM_SLOTS_DEF;
   localparam int SW = SLOT_W_DEF;
   localparam int LW = LEN_W_DEF;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          in_valid = 1'b0, in_last = 1'b0, in_ready;
   logic [DW-1:0] in_data = '0;
   logic          done_valid, done_ready = 1'b1;
   logic [SW-1:0] done_slot;
   logic [LW-1:0] done_len;
   logic          verdict_valid = 1'b0, verdict_ready, verdict_accept = 1'b0;
   logic [SW-1:0] verdict_slot = '0;
   logic          out_valid, out_ready = 1'b1, out_last;
   logic [DW-1:0] out_data;
   logic          err_bad_verdict, err_short_read;
   logic          en_sw, en_w, en_fin, en_sr, en_rd, en_inv;
   logic          rdy_inv = 1'b1;
   logic [SW-1:0] prt_alloc_slot = '0, prt_read_slot, prt_inv_slot;
   logic [DW-1:0] prt_write_data;
   logic [DW:0]   prt_read_entry = '0;
   logic          prt_slot_free;

   always #5 CLK = ~CLK;

   prt_pkt_ctrl dut (
      .CLK(CLK), .RST_N(RST_N),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .done_valid(done_valid), .done_ready(done_ready), .done_slot(done_slot), .done_len(done_len),
      .verdict_valid(verdict_valid), .verdict_ready(verdict_ready),
      .verdict_slot(verdict_slot), .verdict_accept(verdict_accept),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .err_bad_verdict(err_bad_verdict), .err_short_read(err_short_read),
      .prt_EN_start_writing(en_sw), .prt_EN_write(en_w), .prt_EN_finish(en_fin),
      .prt_EN_start_reading(en_sr), .prt_EN_read(en_rd), .prt_EN_invalidate(en_inv),
      .prt_RDY_start_writing(1'b1), .prt_RDY_write(1'b1), .prt_RDY_finish(1'b1),
      .prt_RDY_start_reading(1'b1), .prt_RDY_read(1'b1), .prt_RDY_invalidate(rdy_inv),
      .prt_alloc_slot(prt_alloc_slot), .prt_write_data(prt_write_data),
      .prt_read_slot(prt_read_slot), .prt_inv_slot(prt_inv_slot),
      .prt_read_entry(prt_read_entry), .prt_slot_free(prt_slot_free)
   );

   // ---------------- PRT model and monitors ----------------
   logic [DW-1:0] mem [NS][MD];
   int            plen [NS];
   logic [NS-1:0] alloc = '0;
   int            wptr = 0, rptr = 0, m_wslot = 0, m_rslot = 0, trunc = MD + 10;
   int            n_sw = 0, n_w = 0, n_fin = 0, n_sr = 0, n_rd = 0, n_inv = 0, n_bad = 0, n_viol = 0;
   int            inv_log[$], done_slots[$], done_lens[$], out_bytes[$], out_lasts[$];
   int            n_checks = 0, n_fail = 0;

   assign prt_slot_free = ~&alloc;

   always @(posedge CLK) begin
      if (!RST_N) begin
         alloc          = '0;
         prt_alloc_slot <= '0;
         prt_read_entry <= '0;
      end else begin
         if (en_sw) begin
            automatic int pick = -1;
            for (int s = 0; s < NS; s++) if (!alloc[s] && pick < 0) pick = s;
            if (pick >= 0) begin
               alloc[pick]    = 1'b1;
               prt_alloc_slot <= SW'(pick);
               m_wslot        = pick;
            end
            wptr = 0;
            n_sw++;
         end
         if (en_w) begin
            if (wptr < MD) mem[m_wslot][wptr] = prt_write_data;
            wptr++;
            n_w++;
         end
         if (en_fin) begin plen[m_wslot] = wptr; n_fin++; end
         if (en_sr) begin m_rslot = int'(prt_read_slot); rptr = 0; n_sr++; end
         if (en_rd) begin
            prt_read_entry <= {(rptr < plen[m_rslot]) && (rptr < trunc), mem[m_rslot][(rptr < MD) ? rptr : 0]};
            rptr++;
            n_rd++;
         end
         if (en_inv) begin
            if (!rdy_inv) n_viol++;
            alloc[prt_inv_slot] = 1'b0;
            inv_log.push_back(int'(prt_inv_slot));
            n_inv++;
         end
         if (done_valid && done_ready) begin
            done_slots.push_back(int'(done_slot));
            done_lens.push_back(int'(done_len));
         end
         if (out_valid && out_ready) begin
            out_bytes.push_back(int'(out_data));
            out_lasts.push_back(int'(out_last));
         end
         if (err_bad_verdict) n_bad++;
      end
   end

   function automatic int en_total();
      return n_sw + n_w + n_fin + n_sr + n_rd + n_inv;
   endfunction

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send_pkt(input int len, input int base);
      for (int i = 0; i < len; i++) begin
         automatic int g = 0;
         in_valid = 1'b1;
         in_data  = DW'(base + i);
         in_last  = (i == len - 1);
         @(negedge CLK);
         while (!in_ready && g < 2000) begin @(negedge CLK); g++; end
         if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            break;
         end
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_verdict(input int slot, input bit acc);
      automatic int g = 0;
      verdict_valid  = 1'b1;
      verdict_slot   = SW'(slot);
      verdict_accept = acc;
      @(negedge CLK);
      while (!verdict_ready && g < 2000) begin @(negedge CLK); g++; end
      if (!verdict_ready) check("verdict_ready_timeout", 0, 1);
      tick();
      verdict_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      automatic int g = 0;
      while (done_slots.size() < target && g < 3000) begin tick(); g++; end
      check("done_count", done_slots.size(), target);
   endtask

   task automatic wait_inv(input int target);
      automatic int g = 0;
      while (n_inv < target && g < 3000) begin tick(); g++; end
      check("inv_count", n_inv, target);
   endtask

   // ---------------- stimulus ----------------
   typedef struct {
      int len;
      int base;
      bit accept;
      int exp_slot;
      int exp_len;
      int exp_nout;
      int exp_nsr;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int d0, o0, i0, s0, w0, e0, en0, sw0, blk;

      vecs[0] = '{5, 8'h00, 1'b1, 0, 5, 5, 1};
      vecs[1] = '{3, 8'h10, 1'b0, 0, 3, 0, 0};
      vecs[2] = '{1, 8'hA5, 1'b1, 0, 1, 1, 1};
      vecs[3] = '{7, 8'h40, 1'b1, 0, 7, 7, 1};
      vecs[4] = '{2, 8'hF0, 1'b0, 0, 2, 0, 0};

      // Reset state
      repeat (3) tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_done_valid", done_valid, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_verdict_ready", verdict_ready, 0);
      check("rst_err_bad", err_bad_verdict, 0);
      check("rst_err_short", err_short_read, 0);
      check("rst_enables", {en_sw, en_w, en_fin, en_sr, en_rd, en_inv}, 0);
      RST_N = 1'b1;
      repeat (2) tick();
      check("idle_verdict_ready", verdict_ready, 1);

      // Table-driven store / verdict round trips
      for (int v = 0; v < 5; v++) begin
         d0 = done_slots.size(); o0 = out_bytes.size(); i0 = n_inv; s0 = n_sr;
         send_pkt(vecs[v].len, vecs[v].base);
         wait_done(d0 + 1);
         check($sformatf("v%0d_done_slot", v), done_slots[d0], vecs[v].exp_slot);
         check($sformatf("v%0d_done_len", v), done_lens[d0], vecs[v].exp_len);
         send_verdict(vecs[v].exp_slot, vecs[v].accept);
         wait_inv(i0 + 1);
         check($sformatf("v%0d_out_count", v), out_bytes.size() - o0, vecs[v].exp_nout);
         for (int j = 0; j < vecs[v].exp_nout; j++) begin
            check($sformatf("v%0d_out_data%0d", v, j), out_bytes[o0 + j], (vecs[v].base + j) & 8'hFF);
            check($sformatf("v%0d_out_last%0d", v, j), out_lasts[o0 + j], (j == vecs[v].exp_nout - 1));
         end
         check($sformatf("v%0d_start_reads", v), n_sr - s0, vecs[v].exp_nsr);
         check($sformatf("v%0d_inv_slot", v), inv_log[i0], vecs[v].exp_slot);
         check($sformatf("v%0d_alloc_map", v), alloc, 0);
      end
      check("no_short_yet", err_short_read, 0);

      // Fill all ten slots, verify the eleventh packet stalls until a slot is freed
      d0 = done_slots.size(); o0 = out_bytes.size(); i0 = n_inv;
      for (int k = 0; k < NS; k++) send_pkt(3, k * 3);
      wait_done(d0 + NS);
      for (int k = 0; k < NS; k++) check($sformatf("fill_slot%0d", k), done_slots[d0 + k], k);
      check("fill_slot_free", prt_slot_free, 0);
      sw0 = n_sw; blk = 0;
      fork
         send_pkt(3, 100);
         begin
            repeat (6) begin @(negedge CLK); if (in_ready) blk++; end
            check("full_in_ready", blk, 0);
            check("full_no_alloc", n_sw - sw0, 0);
            send_verdict(3, 1'b1);
         end
      join
      wait_done(d0 + NS + 1);
      check("refill_slot", done_slots[d0 + NS], 3);
      check("refill_len", done_lens[d0 + NS], 3);
      wait_inv(i0 + 1);
      for (int j = 0; j < 3; j++) check($sformatf("slot3_data%0d", j), out_bytes[o0 + j], 9 + j);
      for (int s = 0; s < NS; s++) send_verdict(s, 1'b0);
      wait_inv(i0 + 1 + NS);
      check("drain_alloc_map", alloc, 0);

      // Verdicts for non-pending and out-of-range slots
      e0 = n_bad; en0 = en_total(); o0 = out_bytes.size();
      send_verdict(5, 1'b1);
      repeat (3) tick();
      check("bad_verdict_pulse", n_bad - e0, 1);
      send_verdict(12, 1'b0);
      repeat (3) tick();
      check("bad_verdict_range", n_bad - e0, 2);
      check("bad_verdict_no_en", en_total() - en0, 0);
      check("bad_verdict_no_out", out_bytes.size() - o0, 0);

      // Oversize packet is truncated at the buffer depth and discarded
      w0 = n_w; d0 = done_slots.size(); i0 = n_inv;
      send_pkt(1520, 0);
      wait_inv(i0 + 1);
      check("ovf_writes", n_w - w0, MD);
      check("ovf_no_done", done_slots.size() - d0, 0);
      check("ovf_inv_slot", inv_log[i0], 0);
      check("ovf_alloc_map", alloc, 0);

      // Read-side invalidate beats a simultaneous write-side discard
      rdy_inv = 1'b0;
      d0 = done_slots.size(); i0 = n_inv;
      send_pkt(3, 8'h20);
      wait_done(d0 + 1);
      send_pkt(1520, 0);
      send_verdict(0, 1'b0);
      repeat (3) tick();
      check("arb_hold", n_inv - i0, 0);
      rdy_inv = 1'b1;
      tick();
      rdy_inv = 1'b0;
      check("arb_first_count", n_inv - i0, 1);
      check("arb_first_slot", inv_log[i0], 0);
      repeat (2) tick();
      check("arb_gap_count", n_inv - i0, 1);
      rdy_inv = 1'b1;
      tick();
      check("arb_second_count", n_inv - i0, 2);
      check("arb_second_slot", inv_log[i0 + 1], 1);
      check("arb_alloc_map", alloc, 0);
      check("inv_rdy_respected", n_viol, 0);

      // Short read: the PRT runs dry after two bytes of a four-byte packet
      trunc = 2;
      d0 = done_slots.size(); o0 = out_bytes.size(); i0 = n_inv;
      send_pkt(4, 8'h60);
      wait_done(d0 + 1);
      send_verdict(0, 1'b1);
      wait_inv(i0 + 1);
      trunc = MD + 10;
      check("short_out_count", out_bytes.size() - o0, 3);
      check("short_data0", out_bytes[o0], 8'h60);
      check("short_data1", out_bytes[o0 + 1], 8'h61);
      check("short_last_mid", out_lasts[o0 + 1], 0);
      check("short_last_end", out_lasts[o0 + 2], 1);
      check("short_err", err_short_read, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
